// File: rtl/water_valve_arbiter.sv
// Round-robin arbiter sharing one mains inlet and one drain pump between N machines,
// with a hold-time limit, a dead gap between owners, fill/drain interlock and mains cut-off.

module water_valve_channel #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned GAP      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic [N-1:0] block,
  output logic [N-1:0] gnt,
  output logic [N-1:0] gnt_next_c,
  output logic [N-1:0] expire_c
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [N-1:0]  ONE      = N'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAPW} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [HW-1:0] hold;
  logic [GW-1:0] gcnt;
  logic [N-1:0]  lockout;
  logic [N-1:0]  elig;
  logic          drop;
  logic          expire;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign elig   = req & ~lockout & ~block & {N{enable}};
  assign drop   = !enable || !req[owner];
  assign expire = (state == S_GRANT) && !drop && (hold == HOLD_MAX);

  assign expire_c = expire ? (ONE << owner) : '0;

  // First eligible requester at or after ptr; the smallest offset is written last and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (elig[wrap_inc(ptr, N - 1 - k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_inc(ptr, N - 1 - k);
      end
    end
  end

  // Grant value for the coming edge; the other channel uses it to avoid a same-cycle clash.
  always_comb begin
    gnt_next_c = '0;
    case (state)
      S_IDLE:  if (pick_found) gnt_next_c = ONE << pick_idx;
      S_GRANT: if (!(drop || expire)) gnt_next_c = gnt;
      default: gnt_next_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      ptr     <= '0;
      owner   <= '0;
      hold    <= '0;
      gcnt    <= '0;
      lockout <= '0;
    end else begin
      gnt     <= gnt_next_c;
      lockout <= lockout & req;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state <= S_GRANT;
            owner <= pick_idx;
            hold  <= HW'(1);
            ptr   <= wrap_inc(pick_idx, 32'd1);
          end
        end
        S_GRANT: begin
          if (drop || expire) begin
            state <= S_GAPW;
            gcnt  <= '0;
          end else begin
            hold <= hold + HW'(1);
          end
          // Timed-out owner stays locked out until it drops its request.
          if (expire) lockout[owner] <= 1'b1;
        end
        S_GAPW: begin
          if (gcnt == GAP_LAST) state <= S_IDLE;
          else                  gcnt  <= gcnt + GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

module water_valve_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned GAP      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mains_ok,
  input  logic [N-1:0] fill_req,
  input  logic [N-1:0] drain_req,
  output logic [N-1:0] fill_gnt,
  output logic [N-1:0] drain_gnt,
  output logic         fill_busy,
  output logic         drain_busy,
  output logic [N-1:0] timeout
);
  logic [N-1:0] fill_next;
  logic [N-1:0] drain_next;
  logic [N-1:0] fill_expire;
  logic [N-1:0] drain_expire;

  water_valve_channel #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) u_fill (
    .clk        (clk),
    .reset      (reset),
    .enable     (mains_ok),
    .req        (fill_req),
    .block      (drain_gnt),
    .gnt        (fill_gnt),
    .gnt_next_c (fill_next),
    .expire_c   (fill_expire)
  );

  // Drain also avoids whatever fill is about to grant, so fill wins a same-cycle tie.
  water_valve_channel #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) u_drain (
    .clk        (clk),
    .reset      (reset),
    .enable     (1'b1),
    .req        (drain_req),
    .block      (fill_gnt | fill_next),
    .gnt        (drain_gnt),
    .gnt_next_c (drain_next),
    .expire_c   (drain_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_busy  <= 1'b0;
      drain_busy <= 1'b0;
      timeout    <= '0;
    end else begin
      fill_busy  <= |fill_next;
      drain_busy <= |drain_next;
      timeout    <= fill_expire | drain_expire;
    end
  end

endmodule

// File: tb/tb_water_valve_arbiter.sv
// Self-checking bench for water_valve_arbiter (N=4, MAX_HOLD=8, GAP=2).

module tb_water_valve_arbiter;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mains_ok;
  logic [N-1:0] fill_req;
  logic [N-1:0] drain_req;
  logic [N-1:0] fill_gnt;
  logic [N-1:0] drain_gnt;
  logic         fill_busy;
  logic         drain_busy;
  logic [N-1:0] timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  water_valve_arbiter #(.N(N), .MAX_HOLD(8), .GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .mains_ok   (mains_ok),
    .fill_req   (fill_req),
    .drain_req  (drain_req),
    .fill_gnt   (fill_gnt),
    .drain_gnt  (drain_gnt),
    .fill_busy  (fill_busy),
    .drain_busy (drain_busy),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic [N-1:0] f;
    logic [N-1:0] d;
    logic         m;
    logic [N-1:0] ef;
    logic [N-1:0] ed;
    logic [N-1:0] et;
  } vec_t;

  typedef struct {
    logic [N-1:0] ef;
    logic [N-1:0] ed;
    logic [N-1:0] et;
    string        name;
    int           idx;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic [N-1:0] f, input logic [N-1:0] d, input logic m,
                              input logic [N-1:0] ef, input logic [N-1:0] ed, input logic [N-1:0] et);
    vec_t v;
    v = {f, d, m, ef, ed, et};
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input string what,
                     input logic [N-1:0] got, input logic [N-1:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %b expected %b", name, idx, what, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      cmp(e.name, e.idx, "fill_gnt", fill_gnt, e.ef);
      cmp(e.name, e.idx, "drain_gnt", drain_gnt, e.ed);
      cmp(e.name, e.idx, "timeout", timeout, e.et);
      cmp(e.name, e.idx, "busy{fill,drain}", N'({fill_busy, drain_busy}), N'({|e.ef, |e.ed}));
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
  task automatic step(input logic [N-1:0] f, input logic [N-1:0] d, input logic m,
                      input logic [N-1:0] ef, input logic [N-1:0] ed, input logic [N-1:0] et,
                      input string name, input int idx);
    exp_t e;
    fill_req  = f;
    drain_req = d;
    mains_ok  = m;
    e.ef = ef; e.ed = ed; e.et = et; e.name = name; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_assert++;
      if ((fill_gnt & drain_gnt) != '0) begin
        n_fail++;
        $display("FAIL interlock: fill_gnt %b drain_gnt %b overlap", fill_gnt, drain_gnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int order [5];
    logic [N-1:0] g;

    reset     = 1'b1;
    mains_ok  = 1'b1;
    fill_req  = '0;
    drain_req = '0;

    // Pass-to-next-requester with GAP, then fill/drain tie, then mains cut-off.
    tbl.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0011, 1'b1, 4'b0001, 4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0011, 1'b1, 4'b0001, 4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b1, 4'b0100, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b1000, 1'b1, 4'b0100, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000));

    @(posedge clk);
    #1;
    cmp("reset", 0, "fill_gnt", fill_gnt, 4'b0000);
    cmp("reset", 0, "drain_gnt", drain_gnt, 4'b0000);
    cmp("reset", 0, "timeout", timeout, 4'b0000);
    cmp("reset", 0, "busy{fill,drain}", N'({fill_busy, drain_busy}), 4'b0000);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].f, tbl[i].d, tbl[i].m, tbl[i].ef, tbl[i].ed, tbl[i].et, "table", i);

    // Hold limit: eight grant cycles, a timeout pulse, lockout until the request drops.
    for (int i = 0; i < 8; i++)
      step(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, "hold", i);
    step(4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, "timeout", 0);
    for (int i = 0; i < 5; i++)
      step(4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "lockout", i);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "lockout_clear", 0);
    step(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, "regrant", 0);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "regrant_drop", 0);
    for (int i = 0; i < 3; i++)
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "idle", i);

    // Asynchronous reset while both channels hold a grant.
    step(4'b0001, 4'b0010, 1'b1, 4'b0001, 4'b0010, 4'b0000, "reset_mid", 0);
    step(4'b0001, 4'b0010, 1'b1, 4'b0001, 4'b0010, 4'b0000, "reset_mid", 1);
    #2;
    reset = 1'b1;
    #1;
    cmp("async_reset", 0, "fill_gnt", fill_gnt, 4'b0000);
    cmp("async_reset", 0, "drain_gnt", drain_gnt, 4'b0000);
    cmp("async_reset", 0, "timeout", timeout, 4'b0000);
    cmp("async_reset", 0, "busy{fill,drain}", N'({fill_busy, drain_busy}), 4'b0000);
    fill_req  = '0;
    drain_req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b0000, 4'b0110, 1'b1, 4'b0000, 4'b0010, 4'b0000, "post_reset", 0);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "post_reset", 1);

    // Round-robin rotation with all four requesting and each owner releasing after 3 cycles.
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      g = N'(1) << order[k];
      step(4'b1111, 4'b0000, 1'b1, g, 4'b0000, 4'b0000, "rr_grant", k);
      step(4'b1111, 4'b0000, 1'b1, g, 4'b0000, 4'b0000, "rr_hold", k);
      step(4'b1111, 4'b0000, 1'b1, g, 4'b0000, 4'b0000, "rr_hold", k);
      step(4'b1111 & ~g, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "rr_release", k);
      step(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "rr_gap", k);
      step(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "rr_gap", k);
    end

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
